// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: registered 4-bit code to seven-segment decoder with lamp test,
// blanking, ripple-blank chaining and optional common-anode output polarity.
// Segment order on o_led is {A,B,C,D,E,F,G}, A in bit 6.
// Build option: define BCD_TO_7SEG_HEX_FONT_EN to show hex glyphs for codes
// A-F; otherwise codes A-F use the Code-B font (-, E, H, L, P, blank).
module bcd_to_7seg #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic [3:0] i_bcd,
   input  logic       i_dp,
   input  logic       i_blank,
   input  logic       i_lamp_test,
   input  logic       i_rbi_n,
   output logic [6:0] o_led,
   output logic       o_dp,
   output logic       o_rbo_n
);

   logic [6:0] font_w;
   logic [6:0] led_d, led_q;
   logic       dp_d, dp_q;
   logic       rbo_n_d, rbo_n_q;

   // Glyph lookup for the incoming code (active-high segments)
   always_comb begin
      // NOTE: default assigned first so every path drives font_w; no latch.
      font_w = 7'h00;
      case (i_bcd)
         4'h0:    font_w = 7'h7E;
         4'h1:    font_w = 7'h30;
         4'h2:    font_w = 7'h6D;
         4'h3:    font_w = 7'h79;
         4'h4:    font_w = 7'h33;
         4'h5:    font_w = 7'h5B;
         4'h6:    font_w = 7'h5F;
         4'h7:    font_w = 7'h70;
         4'h8:    font_w = 7'h7F;
         4'h9:    font_w = 7'h7B;
`ifdef BCD_TO_7SEG_HEX_FONT_EN
         4'hA:    font_w = 7'h77;  // A
         4'hB:    font_w = 7'h1F;  // b
         4'hC:    font_w = 7'h4E;  // C
         4'hD:    font_w = 7'h3D;  // d
         4'hE:    font_w = 7'h4F;  // E
         4'hF:    font_w = 7'h47;  // F
`else
         4'hA:    font_w = 7'h01;  // '-'
         4'hB:    font_w = 7'h4F;  // 'E'
         4'hC:    font_w = 7'h37;  // 'H'
         4'hD:    font_w = 7'h0E;  // 'L'
         4'hE:    font_w = 7'h67;  // 'P'
         4'hF:    font_w = 7'h00;  // blank
`endif
         default: font_w = 7'h00;
      endcase
   end

   // Next display value: lamp test beats blank beats ripple blank beats decode
   always_comb begin
      led_d   = font_w;
      dp_d    = i_dp;
      rbo_n_d = 1'b1;
      if (i_lamp_test) begin
         led_d = 7'h7F;
         dp_d  = 1'b1;
      end else if (i_blank) begin
         led_d = 7'h00;
         dp_d  = 1'b0;
      end else if (!i_rbi_n && (i_bcd == 4'h0)) begin
         // Leading zero suppressed; tell the next digit it may blank too.
         led_d   = 7'h00;
         rbo_n_d = 1'b0;
      end
   end

   // Output register: synchronous reset overrides enable; hold when disabled
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so all three registers update together.
      if (!i_reset_n) begin
         led_q   <= 7'h00;
         dp_q    <= 1'b0;
         rbo_n_q <= 1'b1;
      end else if (i_en) begin
         led_q   <= led_d;
         dp_q    <= dp_d;
         rbo_n_q <= rbo_n_d;
      end
   end

   // Display polarity applied after the register; ripple-blank is logic, not a segment
   assign o_led   = ACTIVE_LOW ? ~led_q : led_q;
   assign o_dp    = ACTIVE_LOW ? ~dp_q  : dp_q;
   assign o_rbo_n = rbo_n_q;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// tb_bcd_to_7seg: drives one active-high and one active-low decoder from the
// same stimulus and compares both against a table-driven reference model.
module tb_bcd_to_7seg;

   logic       clk = 1'b0;
   logic       reset_n, en, dp, blank, lamp_test, rbi_n;
   logic [3:0] bcd;
   logic [6:0] led_h, led_l;
   logic       dp_h, dp_l, rbo_h, rbo_l;

   int n_total = 0;
   int n_pass  = 0;

   // Glyph table straight from the font definition, active-high
`ifdef BCD_TO_7SEG_HEX_FONT_EN
   localparam logic [6:0] FONT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`else
   localparam logic [6:0] FONT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};
`endif

   // Model state, packed as {led[6:0], dp, rbo_n}, active-high polarity
   logic [8:0] exp_q = 9'h001;

   always #5 clk = ~clk;

   bcd_to_7seg #(.ACTIVE_LOW(1'b0)) u_dut_hi (
      .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_bcd(bcd), .i_dp(dp),
      .i_blank(blank), .i_lamp_test(lamp_test), .i_rbi_n(rbi_n),
      .o_led(led_h), .o_dp(dp_h), .o_rbo_n(rbo_h)
   );

   bcd_to_7seg #(.ACTIVE_LOW(1'b1)) u_dut_lo (
      .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_bcd(bcd), .i_dp(dp),
      .i_blank(blank), .i_lamp_test(lamp_test), .i_rbi_n(rbi_n),
      .o_led(led_l), .o_dp(dp_l), .o_rbo_n(rbo_l)
   );

   // Reference: what the display should show after an edge with these inputs
   function automatic logic [8:0] model_next(input logic [8:0] cur);
      if (!reset_n)          return {7'h00, 1'b0, 1'b1};
      if (!en)               return cur;
      if (lamp_test)         return {7'h7F, 1'b1, 1'b1};
      if (blank)             return {7'h00, 1'b0, 1'b1};
      if (!rbi_n && bcd == 0) return {7'h00, dp, 1'b0};
      return {FONT[bcd], dp, 1'b1};
   endfunction

   // One clock edge: advance the model, then settle past the edge
   task automatic tick();
      logic [8:0] nxt;
      nxt = model_next(exp_q);
      @(posedge clk);
      #1;
      exp_q = nxt;
   endtask

   task automatic set_idle();
      reset_n = 1'b1; en = 1'b1; bcd = 4'h0; dp = 1'b0;
      blank = 1'b0; lamp_test = 1'b0; rbi_n = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      reset_n = 1'b0; bcd = 4'h8; dp = 1'b1; lamp_test = 1'b1;
      tick();
      tick();
      n_total++;
      if ({led_h, dp_h, rbo_h} !== {7'h00, 1'b0, 1'b1})
         $display("FAIL reset_hi: got led=%h dp=%b rbo_n=%b, want led=00 dp=0 rbo_n=1", led_h, dp_h, rbo_h);
      else n_pass++;
      n_total++;
      if ({led_l, dp_l, rbo_l} !== {7'h7F, 1'b1, 1'b1})
         $display("FAIL reset_lo: got led=%h dp=%b rbo_n=%b, want led=7f dp=1 rbo_n=1", led_l, dp_l, rbo_l);
      else n_pass++;
      set_idle();
   endtask

   task automatic test_sweep();
      set_idle();
      for (int i = 0; i < 16; i++) begin
         bcd = 4'(i);
         tick();
         n_total++;
         if ({led_h, dp_h, rbo_h} !== exp_q)
            $display("FAIL sweep_hi[%0d]: got %h, want %h", i, {led_h, dp_h, rbo_h}, exp_q);
         else n_pass++;
         n_total++;
         if ({led_l, dp_l, rbo_l} !== {~exp_q[8:2], ~exp_q[1], exp_q[0]})
            $display("FAIL sweep_lo[%0d]: got %h, want %h", i, {led_l, dp_l, rbo_l},
                     {~exp_q[8:2], ~exp_q[1], exp_q[0]});
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      set_idle();
      bcd = 4'h4; lamp_test = 1'b1; blank = 1'b1;
      tick();
      n_total++;
      if ({led_h, dp_h, rbo_h} !== {7'h7F, 1'b1, 1'b1})
         $display("FAIL prio_lamp: got led=%h dp=%b rbo_n=%b, want 7f/1/1", led_h, dp_h, rbo_h);
      else n_pass++;
      lamp_test = 1'b0; dp = 1'b1;
      tick();
      n_total++;
      if ({led_h, dp_h, rbo_h} !== {7'h00, 1'b0, 1'b1})
         $display("FAIL prio_blank: got led=%h dp=%b rbo_n=%b, want 00/0/1", led_h, dp_h, rbo_h);
      else n_pass++;
      set_idle();
   endtask

   task automatic test_ripple();
      set_idle();
      rbi_n = 1'b0; bcd = 4'h0; dp = 1'b1;
      tick();
      n_total++;
      if ({led_h, dp_h, rbo_h} !== {7'h00, 1'b1, 1'b0})
         $display("FAIL ripple_zero: got led=%h dp=%b rbo_n=%b, want 00/1/0", led_h, dp_h, rbo_h);
      else n_pass++;
      n_total++;
      if (rbo_l !== 1'b0)
         $display("FAIL ripple_zero_lo_rbo: got %b, want 0", rbo_l);
      else n_pass++;
      bcd = 4'h5; dp = 1'b0;
      tick();
      n_total++;
      if ({led_h, dp_h, rbo_h} !== {7'h5B, 1'b0, 1'b1})
         $display("FAIL ripple_five: got led=%h dp=%b rbo_n=%b, want 5b/0/1", led_h, dp_h, rbo_h);
      else n_pass++;
      set_idle();
   endtask

   task automatic test_hold();
      set_idle();
      bcd = 4'h3;
      tick();
      en = 1'b0; bcd = 4'h7; lamp_test = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (led_h !== 7'h79 || rbo_h !== 1'b1)
            $display("FAIL hold[%0d]: got led=%h rbo_n=%b, want 79/1", i, led_h, rbo_h);
         else n_pass++;
      end
      set_idle();
   endtask

   task automatic test_inversion();
      set_idle();
      bcd = 4'h1; dp = 1'b1;
      tick();
      n_total++;
      if ({led_l, dp_l} !== {7'h4F, 1'b0})
         $display("FAIL invert_one: got led=%h dp=%b, want 4f/0", led_l, dp_l);
      else n_pass++;
      reset_n = 1'b0;
      tick();
      n_total++;
      if ({led_l, dp_l, rbo_l} !== {7'h7F, 1'b1, 1'b1})
         $display("FAIL invert_reset: got led=%h dp=%b rbo_n=%b, want 7f/1/1", led_l, dp_l, rbo_l);
      else n_pass++;
      set_idle();
   endtask

   task automatic test_reset_midstream();
      set_idle();
      bcd = 4'h9;
      tick();
      reset_n = 1'b0;
      tick();
      n_total++;
      if ({led_h, dp_h, rbo_h} !== {7'h00, 1'b0, 1'b1})
         $display("FAIL midreset: got led=%h dp=%b rbo_n=%b, want 00/0/1", led_h, dp_h, rbo_h);
      else n_pass++;
      reset_n = 1'b1; bcd = 4'h2;
      tick();
      n_total++;
      if (led_h !== 7'h6D)
         $display("FAIL after_reset: got led=%h, want 6d", led_h);
      else n_pass++;
      set_idle();
   endtask

   task automatic test_random();
      set_idle();
      for (int i = 0; i < 400; i++) begin
         reset_n   = ($urandom_range(0, 19) != 0);
         en        = ($urandom_range(0, 3) != 0);
         bcd       = 4'($urandom_range(0, 15));
         dp        = 1'($urandom_range(0, 1));
         lamp_test = ($urandom_range(0, 9) == 0);
         blank     = ($urandom_range(0, 7) == 0);
         rbi_n     = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 2) == 0) bcd = 4'h0;
         tick();
         n_total++;
         if ({led_h, dp_h, rbo_h} !== exp_q)
            $display("FAIL random_hi[%0d]: got %h, want %h", i, {led_h, dp_h, rbo_h}, exp_q);
         else n_pass++;
         n_total++;
         if ({led_l, dp_l, rbo_l} !== {~exp_q[8:2], ~exp_q[1], exp_q[0]})
            $display("FAIL random_lo[%0d]: got %h, want %h", i, {led_l, dp_l, rbo_l},
                     {~exp_q[8:2], ~exp_q[1], exp_q[0]});
         else n_pass++;
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      @(negedge clk);
      test_reset();
      test_sweep();
      test_priority();
      test_ripple();
      test_hold();
      test_inversion();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bcd_to_7seg.md
BCD_TO_7SEG -- requirements
Module: bcd_to_7seg

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 0: when 1, o_led and o_dp are inverted at the output for common-anode displays.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port i_en, input, 1 bit: update enable; the output register loads only when high.
REQ-005 SHALL have port i_bcd, input, 4 bits: code to decode.
REQ-006 SHALL have port i_dp, input, 1 bit: decimal-point request.
REQ-007 SHALL have port i_blank, input, 1 bit: force all segments and DP off.
REQ-008 SHALL have port i_lamp_test, input, 1 bit: force all segments and DP on.
REQ-009 SHALL have port i_rbi_n, input, 1 bit: ripple-blank in, active low.
REQ-010 SHALL have port o_led, output, 7 bits: segments {A,B,C,D,E,F,G}, with A in bit 6 and G in bit 0.
REQ-011 SHALL have port o_dp, output, 1 bit: decimal-point segment.
REQ-012 SHALL have port o_rbo_n, output, 1 bit: ripple-blank out, active low.

Function
REQ-013 SHALL register o_led, o_dp and o_rbo_n, with one-cycle latency from sampled inputs to outputs.
REQ-014 SHALL hold o_led, o_dp and o_rbo_n unchanged on any edge with i_en=0 and i_reset_n=1.
REQ-015 SHALL apply this priority on an enabled edge: lamp test, then blank, then ripple blank, then decode.
REQ-016 SHALL, when i_lamp_test=1, load o_led=7'h7F, o_dp=1 and o_rbo_n=1.
REQ-017 SHALL, when i_blank=1 and lamp test is off, load o_led=0, o_dp=0 and o_rbo_n=1.
REQ-018 SHALL, when i_rbi_n=0 and i_bcd=0 (and lamp test and blank are off), load o_led=0 and o_dp=i_dp, and drive o_rbo_n=0.
REQ-019 SHALL otherwise drive o_rbo_n=1 and o_dp=i_dp.
REQ-020 SHALL decode o_led with the Code-B font:
- 0=7E, 1=30, 2=6D, 3=79, 4=33
- 5=5B, 6=5F, 7=70, 8=7F, 9=7B
- A='-'=01, B='E'=4F, C='H'=37, D='L'=0E, E='P'=67, F=blank=00
REQ-021 SHALL apply ACTIVE_LOW inversion after all of the above; inversion SHALL NOT affect o_rbo_n.
REQ-022 SHALL be fully defined for all 16 i_bcd values, with no X outputs and no latches.

Reset
REQ-023 SHALL, on a rising i_clk edge with i_reset_n=0, load o_led=0, o_dp=0 and o_rbo_n=1 (before inversion), overriding i_en and all other inputs.
REQ-024 SHALL, when reset is asserted mid-stream, blank the outputs on the next edge; the first enabled edge after release SHALL decode normally.

Configuration
REQ-025 SHALL, with macro BCD_TO_7SEG_HEX_FONT_EN defined, replace codes A-F with the hex font: A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-026 SHALL, without BCD_TO_7SEG_HEX_FONT_EN, use the Code-B font of REQ-020; codes 0-9 SHALL be identical in both builds.

Verification
REQ-027 SHALL cover reset: hold i_reset_n=0 for 2 edges with i_en=1 and i_bcd=8 -> o_led=00, o_dp=0, o_rbo_n=1.
REQ-028 SHALL cover a full sweep: i_en=1, i_bcd=0..F on consecutive edges -> o_led one cycle later = 7E,30,6D,79,33,5B,5F,70,7F,7B,01,4F,37,0E,67,00 (hex build: 77,1F,4E,3D,4F,47 for A-F).
REQ-029 SHALL cover priority: i_lamp_test=1 and i_blank=1 together -> o_led=7F, o_dp=1; drop lamp test -> o_led=00, o_dp=0.
REQ-030 SHALL cover ripple blank: i_rbi_n=0 with i_bcd=0 -> o_led=00, o_rbo_n=0; i_rbi_n=0 with i_bcd=5 -> o_led=5B, o_rbo_n=1.
REQ-031 SHALL cover hold: load i_bcd=3, then i_en=0 with i_bcd=7 for 3 edges -> o_led stays 79.
REQ-032 SHALL cover inversion: ACTIVE_LOW=1 with i_bcd=1 and i_dp=1 -> o_led=4F, o_dp=0; reset -> o_led=7F, o_dp=1.
